pwm_sample_feeder: RTL and testbench
====================================

Name: pwm_sample_feeder

Overview:
- Upstream neighbour of the audio PWM stage.
- Accepts demodulated audio samples at an irregular rate through a valid/ready handshake and buffers them in a small FIFO.
- Applies a volume gain with symmetric saturation, then presents exactly one sample per PWM period on a data_valid/data strobe. That strobe drives the PWM stage's data_valid/data inputs directly.
- Covers FIFO underruns with zero-order hold.

Parameters:
- IN_WIDTH, 16: width of the signed input sample.
- OUT_WIDTH, 12: width of the signed output sample; equals the PWM stage WIDTH.
- PERIOD_LOG2, 12: log2 of clocks per output strobe; equals the PWM stage WIDTH.
- FIFO_DEPTH, 16: sample FIFO depth; power of two, at least 2.
- GAIN_WIDTH, 8: unsigned gain width, format Q(GAIN_WIDTH-4).4, so 16 = unity.

Ports:
- clock, in, 1: sole clock.
- clock_sreset, in, 1: reset, synchronous and active-high.
- in_valid, in, 1: input sample valid.
- in_ready, out, 1: FIFO can accept a sample.
- in_data, in, IN_WIDTH: signed input sample.
- gain, in, GAIN_WIDTH: unsigned volume, quasi-static.
- mute, in, 1: force output value 0.
- data_valid, out, 1: one-cycle strobe, once per period.
- data, out, OUT_WIDTH: signed sample to the PWM stage.
- underrun, out, 1: one-cycle pulse when a period found the FIFO empty.
- fifo_level, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset state: FIFO emptied, period counter = 0, held value = 0.
  - Output reset values: data_valid = 0, data = 0, underrun = 0, fifo_level = 0, in_ready = 1 from the first cycle after reset.
  - Reset mid-operation discards the FIFO contents and any in-flight pipeline stages.
- Input handshake:
  - Push when in_valid && in_ready.
  - in_ready = (fifo_level != FIFO_DEPTH), registered-consistent with level and never combinational on in_valid.
  - No pass-through when full: in_ready stays low that cycle even if a pop occurs.
- Period counter:
  - PERIOD_LOG2 bits, free-running, wraps.
  - tick = counter all-ones (cycle T).
- Pipeline, fixed latency:
  - T: if FIFO non-empty, pop the head into stage-1 register S1 and set S1 "fresh". If empty, S1 is not fresh.
  - T+1: if fresh, compute the product P = S1 * $signed({1'b0, gain}), full width IN_WIDTH+GAIN_WIDTH+1. Gain is sampled in this cycle.
  - T+2: drive data_valid = 1 for exactly one cycle.
    - If fresh: data = sat(P >>> (4 + IN_WIDTH - OUT_WIDTH)), an arithmetic shift with truncation toward minus infinity. This value becomes the held value.
    - If not fresh: data = held value, and underrun = 1 in the same cycle.
    - If mute = 1 (sampled at T+1): data = 0; the FIFO is still popped and the held value is still updated.
- Saturation: symmetric clip to [-(2^(OUT_WIDTH-1)-1), +(2^(OUT_WIDTH-1)-1)], i.e. ±2047 by default. The most negative code is never emitted.
- data holds its value between strobes; data_valid is otherwise 0.
- Simultaneous push and pop: fifo_level unchanged.
- Push in the tick cycle while the FIFO is empty: the pop sees empty, so the tick is an underrun, and the pushed word is kept for the next period.
- fifo_level counts 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package pwm_audio_pkg:
  - saturation function sat_sym(value, width);
  - constant GAIN_FRAC = 4 and GAIN_UNITY = 16.
- Sub-module sync_fifo:
  - single clock, synchronous reset, registered read data;
  - interface: push/pop/full/empty/level.
  - The feeder contains the counter, the gain pipeline and the hold logic.

Test Plan:
- Reset release, no input, run 3 periods → data_valid at cycles 4097, 8193, 12289 after reset deassertion (T+2 after counter = 4095); data = 0 each time; underrun pulses coincident.
- Push 0x1230 then 0x8000 with gain = 16 → first strobe data = 0x123 (291), second strobe data = -2047 (clipped from -2048); level 2→1→0.
- Push 0x7FF0 with gain = 32 → data = +2047 (saturated); gain = 8 with input 0x0100 → data = 8.
- Push one sample 0x0400 with gain = 16, then starve → strobe 1 data = 64 with no underrun; strobe 2 data = 64 (held) with underrun = 1.
- Push 17 samples back-to-back with no tick → in_ready drops after the 16th accept, the 17th is stalled, fifo_level = 16; after the next tick, in_ready = 1 and the 17th is accepted.
- mute = 1 with 3 queued samples → three strobes with data = 0 and level decrementing; after unmute with the FIFO empty, the strobe shows the held value of the last popped sample with underrun = 1. Assert clock_sreset mid-pipeline (cycle T+1) → no strobe, level = 0, data = 0.

Source files
------------

// File: rtl/pwm_audio_pkg.sv
// Shared constants and helpers for the audio PWM feeder path.
// Gain is unsigned fixed point with four fractional bits.
package pwm_audio_pkg;

    localparam int GAIN_FRAC  = 4;
    localparam int GAIN_UNITY = 16;

    // Symmetric clip: the most negative code of `width` bits is never produced.
    function automatic logic signed [63:0] sat_sym(
        input logic signed [63:0] value,
        input int                 width
    );
        logic signed [63:0] lim;
        lim = (64'sd1 <<< (width - 1)) - 64'sd1;
        if (value > lim) begin
            return lim;
        end else if (value < -lim) begin
            return -lim;
        end
        return value;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and registered read data.
// Pushes when full and pops when empty are ignored.
module sync_fifo
    import pwm_audio_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             push;
    logic             pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = rdata_q;
    assign push    = push_i && !full_o;
    assign pop     = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rdata_q  <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/pwm_sample_feeder.sv
// Buffers irregular audio samples and emits one gained, clipped sample
// per PWM period; an empty FIFO at the period tick repeats the last value.
module pwm_sample_feeder
    import pwm_audio_pkg::*;
#(
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH   = 12,
    parameter int PERIOD_LOG2 = 12,
    parameter int FIFO_DEPTH  = 16,
    parameter int GAIN_WIDTH  = 8
) (
    input  logic                          clock,
    input  logic                          clock_sreset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_WIDTH-1:0]           in_data,
    input  logic [GAIN_WIDTH-1:0]         gain,
    input  logic                          mute,
    output logic                          data_valid,
    output logic [OUT_WIDTH-1:0]          data,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = IN_WIDTH + GAIN_WIDTH + 1;
    localparam int SH = GAIN_FRAC + IN_WIDTH - OUT_WIDTH;

    logic [PERIOD_LOG2-1:0] cnt_q;
    logic                   tick;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [IN_WIDTH-1:0]    s1;
    logic                   fresh_q;
    logic                   stage_q;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   shifted;
    logic [OUT_WIDTH-1:0]   sat_val;
    logic [OUT_WIDTH-1:0]   data_q, data_d;
    logic [OUT_WIDTH-1:0]   hold_q, hold_d;
    logic                   valid_q, valid_d;
    logic                   under_q, under_d;

    assign tick     = &cnt_q;
    assign in_ready = !fifo_full;

    sync_fifo #(
        .WIDTH (IN_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .srst_i  (clock_sreset),
        .push_i  (in_valid && in_ready),
        .wdata_i (in_data),
        .pop_i   (tick),
        .rdata_o (s1),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Both operands widened to the full product width so the product is exact.
    assign prod = $signed({{(PW - IN_WIDTH){s1[IN_WIDTH-1]}}, s1})
                * $signed({{(PW - GAIN_WIDTH){1'b0}}, gain});
    assign shifted = prod >>> SH;
    assign sat_val = OUT_WIDTH'(sat_sym(64'(shifted), OUT_WIDTH));

    always_comb begin
        data_d  = data_q;
        hold_d  = hold_q;
        valid_d = 1'b0;
        under_d = 1'b0;
        if (stage_q) begin
            valid_d = 1'b1;
            if (fresh_q) begin
                hold_d = sat_val;
                data_d = sat_val;
            end else begin
                under_d = 1'b1;
                data_d  = hold_q;
            end
            if (mute) begin
                data_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            cnt_q   <= '0;
            fresh_q <= 1'b0;
            stage_q <= 1'b0;
            data_q  <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            under_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
            fresh_q <= tick && !fifo_empty;
            stage_q <= tick;
            data_q  <= data_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            under_q <= under_d;
        end
    end

    assign data_valid = valid_q;
    assign data       = data_q;
    assign underrun   = under_q;

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Directed bench for pwm_sample_feeder with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pwm_sample_feeder;

    logic        clock;
    logic        clock_sreset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [7:0]  gain;
    logic        mute;
    logic        data_valid;
    logic [11:0] data;
    logic        underrun;
    logic [4:0]  fifo_level;

    int total;
    int bad;
    int cyc;
    int n;

    pwm_sample_feeder dut (
        .clock        (clock),
        .clock_sreset (clock_sreset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .gain         (gain),
        .mute         (mute),
        .data_valid   (data_valid),
        .data         (data),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] v);
        in_valid = 1'b1;
        in_data  = v;
        check("push_ready", int'(in_ready), 1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_strobe(output int cycles);
        cycles = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clock);
            cycles++;
            if (data_valid) break;
        end
        check("strobe_seen", int'(data_valid), 1);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        clock_sreset = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        gain         = 8'd16;
        mute         = 1'b0;
        repeat (3) @(negedge clock);
        clock_sreset = 1'b0;

        check("rst_valid", int'(data_valid), 0);
        check("rst_data", $signed(data), 0);
        check("rst_under", int'(underrun), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_ready", int'(in_ready), 1);

        // Idle periods: strobes every 4096 cycles, all underruns at zero
        cyc = 0;
        for (int k = 0; k < 3; k++) begin
            wait_strobe(n);
            cyc += n;
            check("idle_cycle", cyc, 4097 + 4096 * k);
            check("idle_data", $signed(data), 0);
            check("idle_under", int'(underrun), 1);
            @(negedge clock);
            check("strobe_1cyc", int'(data_valid), 0);
            cyc++;
        end

        // Unity gain, then clip of the most negative input
        gain = 8'd16;
        push(16'h1230);
        push(16'h8000);
        check("lvl_two", int'(fifo_level), 2);
        wait_strobe(n);
        check("unity_data", $signed(data), 291);
        check("unity_under", int'(underrun), 0);
        check("lvl_one", int'(fifo_level), 1);
        wait_strobe(n);
        check("neg_clip", $signed(data), -2047);
        check("lvl_zero", int'(fifo_level), 0);

        // Gain of two saturating, then gain of one half
        gain = 8'd32;
        push(16'h7FF0);
        wait_strobe(n);
        check("pos_sat", $signed(data), 2047);
        gain = 8'd8;
        push(16'h0100);
        wait_strobe(n);
        check("half_gain", $signed(data), 8);

        // Single sample then starvation holds the value
        gain = 8'd16;
        push(16'h0400);
        wait_strobe(n);
        check("one_data", $signed(data), 64);
        check("one_under", int'(underrun), 0);
        @(negedge clock);
        check("data_holds", $signed(data), 64);
        wait_strobe(n);
        check("hold_data", $signed(data), 64);
        check("hold_under", int'(underrun), 1);

        // Fill to capacity; the 17th word waits for the next pop
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 16'(i * 256 + 256);
            check("fill_ready", int'(in_ready), 1);
            @(negedge clock);
        end
        in_data = 16'h1100;
        check("full_ready", int'(in_ready), 0);
        check("full_level", int'(fifo_level), 16);
        for (int i = 0; i < 5000; i++) begin
            if (in_ready) break;
            @(negedge clock);
        end
        check("ready_back", int'(in_ready), 1);
        check("lvl_after_pop", int'(fifo_level), 15);
        @(negedge clock);
        in_valid = 1'b0;
        check("lvl_17th", int'(fifo_level), 16);

        clock_sreset = 1'b1;
        repeat (2) @(negedge clock);
        clock_sreset = 1'b0;
        check("flush_level", int'(fifo_level), 0);
        check("flush_ready", int'(in_ready), 1);

        // Muted strobes still consume samples and update the hold
        mute = 1'b1;
        push(16'h0400);
        push(16'h0800);
        push(16'h0C00);
        for (int k = 0; k < 3; k++) begin
            wait_strobe(n);
            check("mute_data", $signed(data), 0);
            check("mute_under", int'(underrun), 0);
            check("mute_level", int'(fifo_level), 2 - k);
        end
        mute = 1'b0;
        wait_strobe(n);
        check("unmute_data", $signed(data), 192);
        check("unmute_under", int'(underrun), 1);

        // Reset in the cycle after the tick kills the pending strobe
        push(16'h0400);
        push(16'h0800);
        repeat (4093) @(negedge clock);
        check("pre_rst_level", int'(fifo_level), 1);
        clock_sreset = 1'b1;
        @(negedge clock);
        clock_sreset = 1'b0;
        check("midrst_valid", int'(data_valid), 0);
        check("midrst_level", int'(fifo_level), 0);
        check("midrst_data", $signed(data), 0);
        check("midrst_under", int'(underrun), 0);
        @(negedge clock);
        check("midrst_quiet", int'(data_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
